// File: rtl/rename_map_table_ckpt_if.sv
// ---------------------------------------------------------------------------
// rename_map_table_ckpt_if
//
// Purpose: bundles the rename-stage signals of rename_map_table_ckpt.
//   The master side is decode / recovery control. The slave side is the map
//   table itself.
//
// Signal summary (per-lane signals are packed [WIDTH] arrays):
//   ext_stall                   downstream stall
//   valid_instr, valid_new_rd   lane holds an instruction / lane writes rd
//   rs1, rs2, rd                architectural sources / destination
//   phys_rd                     newly allocated physical register
//   ckpt_req                    lane is a branch that wants a checkpoint
//   restore_valid, restore_id   mispredict recovery to a checkpoint
//   release_valid               oldest checkpoint resolved correctly
//   phys_rs1, phys_rs2, old_rd  renamed sources / previous mapping of rd
//   ckpt_id, ckpt_full          slot for a granted checkpoint / buffer full
//   int_stall                   group not accepted this cycle
//
// Optional macro COMMIT_MAP_EN adds the following signals:
//   commit_valid, commit_rd, commit_prd, flush_all
// ---------------------------------------------------------------------------
`ifndef NUM_PR
`define NUM_PR 64
`endif

interface rename_map_table_ckpt_if #(
  parameter int WIDTH    = 2,
  parameter int NUM_AR   = 32,
  parameter int NUM_PR   = `NUM_PR,
  parameter int NUM_CKPT = 4
);
  localparam int ARW = $clog2(NUM_AR);
  localparam int PRW = $clog2(NUM_PR);
  localparam int CKW = $clog2(NUM_CKPT);

  logic                      ext_stall;
  logic [WIDTH-1:0]          valid_instr;
  logic [WIDTH-1:0][ARW-1:0] rs1;
  logic [WIDTH-1:0][ARW-1:0] rs2;
  logic [WIDTH-1:0][ARW-1:0] rd;
  logic [WIDTH-1:0]          valid_new_rd;
  logic [WIDTH-1:0][PRW-1:0] phys_rd;
  logic [WIDTH-1:0]          ckpt_req;
  logic                      restore_valid;
  logic [CKW-1:0]            restore_id;
  logic                      release_valid;

  logic [WIDTH-1:0][PRW-1:0] phys_rs1;
  logic [WIDTH-1:0][PRW-1:0] phys_rs2;
  logic [WIDTH-1:0][PRW-1:0] old_rd;
  logic [CKW-1:0]            ckpt_id;
  logic                      ckpt_full;
  logic                      int_stall;

`ifdef COMMIT_MAP_EN
  logic [WIDTH-1:0]          commit_valid;
  logic [WIDTH-1:0][ARW-1:0] commit_rd;
  logic [WIDTH-1:0][PRW-1:0] commit_prd;
  logic                      flush_all;

  modport master (
    output ext_stall, valid_instr, rs1, rs2, rd, valid_new_rd, phys_rd,
           ckpt_req, restore_valid, restore_id, release_valid,
           commit_valid, commit_rd, commit_prd, flush_all,
    input  phys_rs1, phys_rs2, old_rd, ckpt_id, ckpt_full, int_stall
  );

  modport slave (
    input  ext_stall, valid_instr, rs1, rs2, rd, valid_new_rd, phys_rd,
           ckpt_req, restore_valid, restore_id, release_valid,
           commit_valid, commit_rd, commit_prd, flush_all,
    output phys_rs1, phys_rs2, old_rd, ckpt_id, ckpt_full, int_stall
  );
`else
  modport master (
    output ext_stall, valid_instr, rs1, rs2, rd, valid_new_rd, phys_rd,
           ckpt_req, restore_valid, restore_id, release_valid,
    input  phys_rs1, phys_rs2, old_rd, ckpt_id, ckpt_full, int_stall
  );

  modport slave (
    input  ext_stall, valid_instr, rs1, rs2, rd, valid_new_rd, phys_rd,
           ckpt_req, restore_valid, restore_id, release_valid,
    output phys_rs1, phys_rs2, old_rd, ckpt_id, ckpt_full, int_stall
  );
`endif

endinterface

// File: rtl/rename_map_table_ckpt.sv
// ---------------------------------------------------------------------------
// rename_map_table_ckpt
//
// Purpose: register rename map table with built-in branch checkpoints.
//   Each cycle it renames a group of WIDTH instructions. Sources see the
//   writes of older lanes in the same group.
//   A branch lane can snapshot the map into a circular buffer of NUM_CKPT
//   slots. A mispredict restores the map from a slot chosen by its id.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    rename_map_table_ckpt_if.slave (see the interface header)
//
// Optional macro COMMIT_MAP_EN adds a retirement map fed by the commit
//   lanes. With this macro, flush_all rebuilds the speculative map from the
//   retirement map and empties the checkpoint buffer.
// ---------------------------------------------------------------------------
`ifndef NUM_PR
`define NUM_PR 64
`endif

module rename_map_table_ckpt #(
  parameter int WIDTH    = 2,
  parameter int NUM_AR   = 32,
  parameter int NUM_PR   = `NUM_PR,
  parameter int NUM_CKPT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  rename_map_table_ckpt_if.slave bus
);

  localparam int PRW = $clog2(NUM_PR);
  localparam int ARW = $clog2(NUM_AR);
  localparam int CKW = $clog2(NUM_CKPT);
  localparam int CNW = CKW + 1;

  typedef logic [NUM_AR-1:0][PRW-1:0] map_t;

  map_t                   map_q, map_d;
  map_t [NUM_CKPT-1:0]    ckpt_q, ckpt_d;
  logic [CKW-1:0]         head_q, head_d;
  logic [CKW-1:0]         tail_q, tail_d;
  logic [CNW-1:0]         count_q, count_d;

  logic [WIDTH-1:0]          we;
  logic [WIDTH-1:0]          grant_mask;
  logic                      grant_any;
  logic                      grant_taken;
  logic                      snap_open;
  map_t                      full_map;
  map_t                      snap_map;
  logic                      ckpt_full_c;
  logic                      int_stall_c;
  logic                      accept;
  logic                      release_ok;
  logic [CKW-1:0]            restore_off;
  logic [CNW-1:0]            count_mid;
  logic [WIDTH-1:0][PRW-1:0] phys_rs1_c;
  logic [WIDTH-1:0][PRW-1:0] phys_rs2_c;
  logic [WIDTH-1:0][PRW-1:0] old_rd_c;

`ifdef COMMIT_MAP_EN
  map_t rmap_q, rmap_d;
`endif

  // A lane writes the map only if it is real, asks for rd and rd is not AR 0
  always_comb begin
    we = '0;
    for (int j = 0; j < WIDTH; j++) begin
      we[j] = bus.valid_instr[j] & bus.valid_new_rd[j] & (bus.rd[j] != '0);
    end
  end

  // Only the lowest requesting lane gets a checkpoint
  always_comb begin
    grant_mask = '0;
    grant_any  = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!grant_any && bus.valid_instr[k] && bus.ckpt_req[k]) begin
        grant_mask[k] = 1'b1;
        grant_any     = 1'b1;
      end
    end
  end

  // Map after the whole group, and the snapshot that stops at the granted
  // branch lane (the branch lane's own write is included)
  always_comb begin
    full_map  = map_q;
    snap_map  = map_q;
    snap_open = 1'b1;
    for (int j = 0; j < WIDTH; j++) begin
      if (we[j]) begin
        full_map[bus.rd[j]] = bus.phys_rd[j];
        if (snap_open) begin
          snap_map[bus.rd[j]] = bus.phys_rd[j];
        end
      end
      if (grant_mask[j]) begin
        snap_open = 1'b0;
      end
    end
  end

  // Source lookup with bypass from older lanes of the same group; the
  // highest older lane wins because the loop ends on it
  always_comb begin
    phys_rs1_c = '0;
    phys_rs2_c = '0;
    old_rd_c   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      phys_rs1_c[i] = map_q[bus.rs1[i]];
      phys_rs2_c[i] = map_q[bus.rs2[i]];
      old_rd_c[i]   = map_q[bus.rd[i]];
      for (int j = 0; j < i; j++) begin
        if (we[j] && (bus.rd[j] == bus.rs1[i])) phys_rs1_c[i] = bus.phys_rd[j];
        if (we[j] && (bus.rd[j] == bus.rs2[i])) phys_rs2_c[i] = bus.phys_rd[j];
        if (we[j] && (bus.rd[j] == bus.rd[i]))  old_rd_c[i]   = bus.phys_rd[j];
      end
      if (bus.rs1[i] == '0) phys_rs1_c[i] = '0;
      if (bus.rs2[i] == '0) phys_rs2_c[i] = '0;
      if (bus.rd[i]  == '0) old_rd_c[i]   = '0;
    end
  end

  assign ckpt_full_c = (count_q == CNW'(NUM_CKPT));
  assign restore_off = bus.restore_id - head_q;

  // A full buffer blocks a checkpoint unless the head frees a slot this cycle
`ifdef COMMIT_MAP_EN
  assign int_stall_c = bus.flush_all | bus.restore_valid |
                       (grant_any & ckpt_full_c & ~bus.release_valid);
`else
  assign int_stall_c = bus.restore_valid |
                       (grant_any & ckpt_full_c & ~bus.release_valid);
`endif

  assign accept      = ~bus.ext_stall & ~int_stall_c;
  assign grant_taken = accept & grant_any;

`ifdef COMMIT_MAP_EN
  // Retirement map, younger commit lanes win, AR 0 never written
  always_comb begin
    rmap_d = rmap_q;
    for (int j = 0; j < WIDTH; j++) begin
      if (bus.commit_valid[j] && (bus.commit_rd[j] != '0)) begin
        rmap_d[bus.commit_rd[j]] = bus.commit_prd[j];
      end
    end
  end
`endif

  // Next map / checkpoint state. A restore is resolved first, and a release
  // is then applied to the result. Because a restore keeps its own slot
  // live, a release on the same cycle always has a slot to free.
  always_comb begin
    map_d      = map_q;
    ckpt_d     = ckpt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_mid  = count_q;
    count_d    = count_q;
    release_ok = 1'b0;

    if (bus.restore_valid) begin
      map_d     = ckpt_q[bus.restore_id];
      tail_d    = bus.restore_id + 1'b1;
      count_mid = {1'b0, restore_off} + 1'b1;
    end else if (accept) begin
      map_d = full_map;
      if (grant_any) begin
        ckpt_d[tail_q] = snap_map;
        tail_d         = tail_q + 1'b1;
      end
    end

    release_ok = bus.release_valid & (count_mid != '0);
    count_d    = count_mid + CNW'(grant_taken) - CNW'(release_ok);
    head_d     = head_q + CKW'(release_ok);

`ifdef COMMIT_MAP_EN
    if (bus.flush_all) begin
      map_d   = rmap_d;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
`endif
  end

  // State registers; reset restores the identity map and an empty buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AR; i++) begin
        map_q[i] <= PRW'(i);
      end
      ckpt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      map_q   <= map_d;
      ckpt_q  <= ckpt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef COMMIT_MAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AR; i++) begin
        rmap_q[i] <= PRW'(i);
      end
    end else begin
      rmap_q <= rmap_d;
    end
  end
`endif

  assign bus.phys_rs1  = phys_rs1_c;
  assign bus.phys_rs2  = phys_rs2_c;
  assign bus.old_rd    = old_rd_c;
  assign bus.ckpt_id   = tail_q;
  assign bus.ckpt_full = ckpt_full_c;
  assign bus.int_stall = int_stall_c;

  // A restore must name a live slot, i.e. lie in [head, tail)
  assert property (@(posedge clk) disable iff (!reset)
                   bus.restore_valid |-> ({1'b0, restore_off} < count_q));

endmodule

// File: tb/tb_rename_map_table_ckpt.sv
// ---------------------------------------------------------------------------
// tb_rename_map_table_ckpt
//
// Purpose: directed, self-checking bench for rename_map_table_ckpt.
//   Default parameters are used: WIDTH=2, NUM_AR=32, NUM_PR=64, NUM_CKPT=4.
//   The map is observed through lane 0's rs1 read port while every lane is
//   idle. All expected values are hand-computed constants.
//   The COMMIT_MAP_EN section is compiled only when that macro is defined.
// ---------------------------------------------------------------------------
module tb_rename_map_table_ckpt;

  localparam int WIDTH    = 2;
  localparam int NUM_AR   = 32;
  localparam int NUM_PR   = 64;
  localparam int NUM_CKPT = 4;

  logic clk;
  logic reset;
  int   error_count;
  int   check_count;

  rename_map_table_ckpt_if #(
    .WIDTH(WIDTH), .NUM_AR(NUM_AR), .NUM_PR(NUM_PR), .NUM_CKPT(NUM_CKPT)
  ) rif ();

  rename_map_table_ckpt #(
    .WIDTH(WIDTH), .NUM_AR(NUM_AR), .NUM_PR(NUM_PR), .NUM_CKPT(NUM_CKPT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rif)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count it, report any difference
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive every input to its idle value
  task automatic clearInputs();
    rif.ext_stall     = 1'b0;
    rif.valid_instr   = '0;
    rif.rs1           = '0;
    rif.rs2           = '0;
    rif.rd            = '0;
    rif.valid_new_rd  = '0;
    rif.phys_rd       = '0;
    rif.ckpt_req      = '0;
    rif.restore_valid = 1'b0;
    rif.restore_id    = '0;
    rif.release_valid = 1'b0;
`ifdef COMMIT_MAP_EN
    rif.commit_valid  = '0;
    rif.commit_rd     = '0;
    rif.commit_prd    = '0;
    rif.flush_all     = 1'b0;
`endif
  endtask

  // Fill one rename lane
  task automatic setLane(input int lane, input bit v, input int s1, input int s2,
                         input int d, input bit wr, input int prd, input bit req);
    rif.valid_instr[lane]  = v;
    rif.rs1[lane]          = 5'(s1);
    rif.rs2[lane]          = 5'(s2);
    rif.rd[lane]           = 5'(d);
    rif.valid_new_rd[lane] = wr;
    rif.phys_rd[lane]      = 6'(prd);
    rif.ckpt_req[lane]     = req;
  endtask

  // Let the current inputs take effect at the next rising edge, then idle
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  // Read one map entry through an idle lane 0
  task automatic probeMap(input string tag, input int ar, input int expected);
    clearInputs();
    rif.rs1[0] = 5'(ar);
    #1;
    checkOutput(tag, 32'(rif.phys_rs1[0]), 32'(expected));
  endtask

  initial begin
    error_count = 0;
    check_count = 0;
    reset = 1'b0;
    clearInputs();
    #12;
    checkOutput("reset_ckpt_id",   32'(rif.ckpt_id),   32'd0);
    checkOutput("reset_ckpt_full", 32'(rif.ckpt_full), 32'd0);
    checkOutput("reset_int_stall", 32'(rif.int_stall), 32'd0);
    probeMap("reset_map17", 17, 17);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Plain reads; lane 0 writes rd 0, which must not bypass to a zero source
    setLane(0, 1'b1, 5, 0, 0, 1'b1, 33, 1'b0);
    setLane(1, 1'b1, 7, 0, 0, 1'b0, 0,  1'b0);
    #1;
    checkOutput("read_rs1_l0",    32'(rif.phys_rs1[0]), 32'd5);
    checkOutput("read_rs1_l1",    32'(rif.phys_rs1[1]), 32'd7);
    checkOutput("zero_src_l1",    32'(rif.phys_rs2[1]), 32'd0);
    checkOutput("zero_old_rd_l0", 32'(rif.old_rd[0]),   32'd0);
    applyStimulus();
    probeMap("map1_untouched", 1, 1);

    // Intra-group bypass: lane 0 renames 3->40, lane 1 reads 3 and renames 3->41
    setLane(0, 1'b1, 0, 0, 3, 1'b1, 40, 1'b0);
    setLane(1, 1'b1, 3, 3, 3, 1'b1, 41, 1'b0);
    #1;
    checkOutput("bypass_rs1_l1", 32'(rif.phys_rs1[1]), 32'd40);
    checkOutput("bypass_rs2_l1", 32'(rif.phys_rs2[1]), 32'd40);
    checkOutput("bypass_old_l1", 32'(rif.old_rd[1]),   32'd40);
    checkOutput("old_rd_l0",     32'(rif.old_rd[0]),   32'd3);
    applyStimulus();
    probeMap("map3_youngest", 3, 41);

    // Checkpoint on lane 1 after 4->50 and 6->51
    setLane(0, 1'b1, 0, 0, 4, 1'b1, 50, 1'b0);
    setLane(1, 1'b1, 4, 0, 6, 1'b1, 51, 1'b1);
    #1;
    checkOutput("ckpt0_id",    32'(rif.ckpt_id),     32'd0);
    checkOutput("ckpt0_stall", 32'(rif.int_stall),   32'd0);
    checkOutput("ckpt0_byp",   32'(rif.phys_rs1[1]), 32'd50);
    applyStimulus();
    checkOutput("ckpt0_tail", 32'(rif.ckpt_id), 32'd1);

    // Overwrite 4->60 after the checkpoint
    setLane(0, 1'b1, 0, 0, 4, 1'b1, 60, 1'b0);
    applyStimulus();
    probeMap("map4_over", 4, 60);

    // Restore slot 0; the concurrent rename of 4->62 must be dropped
    rif.restore_valid = 1'b1;
    rif.restore_id    = 2'd0;
    setLane(0, 1'b1, 0, 0, 4, 1'b1, 62, 1'b0);
    #1;
    checkOutput("restore_stall", 32'(rif.int_stall), 32'd1);
    applyStimulus();
    probeMap("restore_map4", 4, 50);
    probeMap("restore_map6", 6, 51);
    probeMap("restore_map3", 3, 41);
    checkOutput("restore_tail", 32'(rif.ckpt_id),   32'd1);
    checkOutput("restore_full", 32'(rif.ckpt_full), 32'd0);

    // Both lanes request: only lane 0 is granted; lane 1 writes 8->20 after it
    setLane(0, 1'b1, 0, 0, 0, 1'b0, 0,  1'b1);
    setLane(1, 1'b1, 0, 0, 8, 1'b1, 20, 1'b1);
    #1;
    checkOutput("dual_req_id", 32'(rif.ckpt_id), 32'd1);
    applyStimulus();
    checkOutput("dual_req_tail", 32'(rif.ckpt_id), 32'd2);
    setLane(0, 1'b1, 0, 0, 0, 1'b0, 0, 1'b1);
    applyStimulus();
    checkOutput("three_not_full", 32'(rif.ckpt_full), 32'd0);
    setLane(1, 1'b1, 0, 0, 0, 1'b0, 0, 1'b1);
    #1;
    checkOutput("lane1_req_id", 32'(rif.ckpt_id), 32'd3);
    applyStimulus();
    checkOutput("four_full",  32'(rif.ckpt_full), 32'd1);
    checkOutput("wrap_tail",  32'(rif.ckpt_id),   32'd0);

    // Fifth request while full is stalled and leaves the map alone
    setLane(0, 1'b1, 0, 0, 9, 1'b1, 30, 1'b1);
    #1;
    checkOutput("full_stall", 32'(rif.int_stall), 32'd1);
    applyStimulus();
    probeMap("full_map9", 9, 9);

    // Same request with a release is accepted into wrapped slot 0
    setLane(0, 1'b1, 0, 0, 9, 1'b1, 30, 1'b1);
    rif.release_valid = 1'b1;
    #1;
    checkOutput("rel_no_stall", 32'(rif.int_stall), 32'd0);
    checkOutput("rel_wrap_id",  32'(rif.ckpt_id),   32'd0);
    applyStimulus();
    probeMap("rel_map9", 9, 30);
    checkOutput("rel_still_full", 32'(rif.ckpt_full), 32'd1);

    // Slot 1 was taken before lane 1 wrote 8->20, so map[8] reverts to 8
    rif.restore_valid = 1'b1;
    rif.restore_id    = 2'd1;
    applyStimulus();
    probeMap("slot1_map8", 8, 8);
    probeMap("slot1_map9", 9, 9);
    checkOutput("slot1_tail", 32'(rif.ckpt_id),   32'd2);
    checkOutput("slot1_full", 32'(rif.ckpt_full), 32'd0);

    // Asynchronous reset in the middle of a cycle clears everything at once
    setLane(0, 1'b1, 0, 0, 4, 1'b1, 63, 1'b1);
    rif.ext_stall = 1'b1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_ckpt_id", 32'(rif.ckpt_id),   32'd0);
    checkOutput("midrst_full",    32'(rif.ckpt_full), 32'd0);
    probeMap("midrst_map4", 4, 4);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Three checkpoints: slot0 {5:45}, slot1 {5:46,6:47}, slot2 {5:46}
    setLane(0, 1'b1, 0, 0, 5, 1'b1, 45, 1'b1);
    #1;
    checkOutput("g0_id", 32'(rif.ckpt_id), 32'd0);
    applyStimulus();
    setLane(0, 1'b1, 0, 0, 5, 1'b1, 46, 1'b0);
    setLane(1, 1'b1, 0, 0, 6, 1'b1, 47, 1'b1);
    #1;
    checkOutput("g1_id", 32'(rif.ckpt_id), 32'd1);
    applyStimulus();
    setLane(0, 1'b1, 0, 0, 0, 1'b0, 0,  1'b1);
    setLane(1, 1'b1, 0, 0, 5, 1'b1, 48, 1'b0);
    applyStimulus();
    checkOutput("g2_tail", 32'(rif.ckpt_id), 32'd3);
    probeMap("g2_map5", 5, 48);

    // Restore slot 1 with a release in the same cycle: tail=2, head=1, count=1
    rif.restore_valid = 1'b1;
    rif.restore_id    = 2'd1;
    rif.release_valid = 1'b1;
    #1;
    checkOutput("rr_stall", 32'(rif.int_stall), 32'd1);
    applyStimulus();
    checkOutput("rr_tail", 32'(rif.ckpt_id), 32'd2);
    probeMap("rr_map5", 5, 46);
    probeMap("rr_map6", 6, 47);

    // With count=1, exactly three more grants fill the buffer
    setLane(0, 1'b1, 0, 0, 0, 1'b0, 0, 1'b1);
    applyStimulus();
    setLane(0, 1'b1, 0, 0, 0, 1'b0, 0, 1'b1);
    applyStimulus();
    checkOutput("cnt3_not_full", 32'(rif.ckpt_full), 32'd0);
    setLane(0, 1'b1, 0, 0, 0, 1'b0, 0, 1'b1);
    #1;
    checkOutput("cnt_wrap_id", 32'(rif.ckpt_id), 32'd0);
    applyStimulus();
    checkOutput("cnt4_full", 32'(rif.ckpt_full), 32'd1);
    checkOutput("cnt4_tail", 32'(rif.ckpt_id),   32'd1);

    // head=1, so slot 0 is the youngest live slot and restoring it keeps four
    rif.restore_valid = 1'b1;
    rif.restore_id    = 2'd0;
    applyStimulus();
    checkOutput("head_full", 32'(rif.ckpt_full), 32'd1);
    checkOutput("head_tail", 32'(rif.ckpt_id),   32'd1);
    probeMap("head_map5", 5, 46);

`ifdef COMMIT_MAP_EN
    // Commit 9->70 while speculatively renaming 9->80
    setLane(0, 1'b1, 0, 0, 9, 1'b1, 80, 1'b0);
    rif.commit_valid[0] = 1'b1;
    rif.commit_rd[0]    = 5'd9;
    rif.commit_prd[0]   = 6'd70;
    applyStimulus();
    probeMap("spec_map9", 9, 80);

    // Flush with same-cycle commits to AR 10; the younger lane wins
    rif.flush_all       = 1'b1;
    rif.commit_valid    = 2'b11;
    rif.commit_rd[0]    = 5'd10;
    rif.commit_prd[0]   = 6'd71;
    rif.commit_rd[1]    = 5'd10;
    rif.commit_prd[1]   = 6'd72;
    #1;
    checkOutput("flush_stall", 32'(rif.int_stall), 32'd1);
    applyStimulus();
    probeMap("flush_map9",  9,  70);
    probeMap("flush_map10", 10, 72);
    checkOutput("flush_full", 32'(rif.ckpt_full), 32'd0);
    checkOutput("flush_tail", 32'(rif.ckpt_id),   32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/rename_map_table_ckpt.md
Name: rename_map_table_ckpt

Overview:
- Parametrised next-generation register rename map table: WIDTH-wide rename group, NUM_AR architectural to NUM_PR physical mappings.
- Holds NUM_CKPT internal branch checkpoints in a circular buffer, so checkpoint storage no longer lives outside the table.
- Sits in the rename stage between decode and the free list / ROB; restores on mispredict by checkpoint id.

Parameters:
- WIDTH, 2, rename lanes per cycle (1..4).
- NUM_AR, 32, architectural registers; AR 0 hardwired to PR 0.
- NUM_PR, `NUM_PR, physical registers; PRW = $clog2(NUM_PR), ARW = $clog2(NUM_AR).
- NUM_CKPT, 4, checkpoint slots (power of 2); CKW = $clog2(NUM_CKPT).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ext_stall  in  1  downstream stall; no map/checkpoint state change from rename.
- valid_instr  in  [WIDTH]x1  lane holds a real instruction.
- rs1, rs2, rd  in  [WIDTH]xARW  source/destination architectural regs.
- valid_new_rd  in  [WIDTH]x1  lane writes rd.
- phys_rd  in  [WIDTH]xPRW  newly allocated PR per lane.
- ckpt_req  in  [WIDTH]x1  lane is a branch needing a checkpoint.
- ckpt_id  out  CKW  slot assigned to the granted checkpoint.
- ckpt_full  out  1  count == NUM_CKPT.
- restore_valid  in  1  mispredict recovery.
- restore_id  in  CKW  checkpoint to restore.
- release_valid  in  1  oldest checkpoint's branch resolved correctly; free head.
- phys_rs1, phys_rs2, old_rd  out  [WIDTH]xPRW  renamed sources / previous mapping of rd.
- int_stall  out  1  rename group not accepted this cycle.

Behaviour:
- Reset (async, reset low): map[i]=i; head=tail=0; count=0; ckpt_id=0; ckpt_full=0. Combinational outputs follow the reset map.
- Effective write of lane j: we[j] = valid_instr[j] & valid_new_rd[j] & (rd[j]!=0).
- Reads are combinational.
  - Lane i rs1/rs2/old_rd takes phys_rd[j] of the highest j<i with we[j] and rd[j] equal to the source.
  - Otherwise map[src]. Source 0 always yields 0.
- Checkpoint grant:
  - Only the lowest lane k with valid_instr[k] & ckpt_req[k] is granted; requests on higher lanes in the same group are ignored (decode issues at most one branch per group).
  - The snapshot is the map after applying we[0..k] in lane order, younger winning.
  - ckpt_id = tail, combinational.
- int_stall = restore_valid | (granted request & ckpt_full).
- Accept condition: ~ext_stall & ~int_stall.
  - On accept at posedge, apply we[0..WIDTH-1] in lane order; the youngest lane wins on the same rd.
  - If a checkpoint was granted: ckpt[tail] <= snapshot; tail++ (mod NUM_CKPT); count++.
- Restore (priority over rename, single cycle):
  - map <= ckpt[restore_id].
  - tail <= restore_id + 1, keeping the restored slot, which the branch still owns.
  - count <= ((restore_id - head) mod NUM_CKPT) + 1.
  - restore_id outside [head, tail) is illegal; assertion only.
- Release: head++, count--.
  - With count==0, release is ignored.
  - Simultaneous restore and release: restore computed first, then release applied to the result. If that empties the buffer, head = tail.
- Rename-grant plus release in the same cycle: count unchanged, both pointers advance.
  - A group is not blocked by ckpt_full when release_valid is also asserted that cycle.
- Reset low mid-operation: all state cleared immediately, regardless of restore or stall.

Optional Feature:
- Macro COMMIT_MAP_EN.
  - Adds ports commit_valid [WIDTH]x1, commit_rd [WIDTH]xARW, commit_prd [WIDTH]xPRW, flush_all 1.
  - Maintains a retirement map updated in lane order on each commit; the youngest lane wins, and rd 0 is ignored.
  - flush_all has priority over restore and rename: map <= retirement map (including same-cycle commits); head=tail=count=0; int_stall=1.
- Without the macro: these ports and the retirement map are absent; recovery is checkpoint restore only.

Test Plan:
- Reset, then WIDTH=2, rs1[0]=5, rs1[1]=7 -> phys_rs1 = {5,7}; rd[0]=0 with valid_new_rd[0] -> map[0] stays 0.
- Lane0 rd=3, phys_rd=40; lane1 rs1=3, rs2=3, rd=3, phys_rd=41 -> lane1 phys_rs1=phys_rs2=40, old_rd[1]=40; next cycle map[3]=41.
- Lane0 rd=4→50, lane1 ckpt_req with rd=6→51 -> ckpt_id=0; slot 0 holds map[4]=50, map[6]=51. Later overwrite 4→60, restore_id=0 -> map[4]=50; int_stall=1 for that cycle.
- Four granted checkpoints -> ckpt_full=1; a fifth request -> int_stall=1, map unchanged. Same request with release_valid=1 -> accepted, ckpt_id=0 (wrap).
- Checkpoints 0..2 live; restore_id=1 and release_valid together -> tail=2, head=1, count=1.
- COMMIT_MAP_EN: commit 9→70, rename 9→80, flush_all -> map[9]=70, count=0, int_stall=1.
